// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS burst controller:
//   - state_e         : burst sequencer states
//   - TAPS_LN*        : maximal-length Fibonacci tap masks (new MSB = ^(state & mask))
//   - ZERO_SEED_SUB   : value loaded in place of an all-zero seed (which would lock up)
//   - default_taps()  : tap mask lookup by LFSR length
// -----------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Tap masks for a right-shifting Fibonacci LFSR; bit i set means state[i]
    // feeds the XOR that becomes the new MSB. Bit 0 is always part of the mask.
    localparam logic [31:0] TAPS_LN3  = 32'h0000_0003;
    localparam logic [31:0] TAPS_LN4  = 32'h0000_0003;
    localparam logic [31:0] TAPS_LN5  = 32'h0000_0005;
    localparam logic [31:0] TAPS_LN7  = 32'h0000_0003;
    localparam logic [31:0] TAPS_LN8  = 32'h0000_002d;
    localparam logic [31:0] TAPS_LN16 = 32'h0000_6801;

    // The all-zero state is a fixed point of the LFSR, so it is never loaded.
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    // Lengths without an entry fall back to a short mask that is not maximal;
    // such instances should pass TAPS explicitly.
    function automatic logic [31:0] default_taps(input int ln);
        logic [31:0] taps;
        case (ln)
            3:       taps = TAPS_LN3;
            4:       taps = TAPS_LN4;
            5:       taps = TAPS_LN5;
            7:       taps = TAPS_LN7;
            8:       taps = TAPS_LN8;
            16:      taps = TAPS_LN16;
            default: taps = 32'h0000_0003;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_core
// Right-shifting Fibonacci LFSR. Each enabled cycle shifts right and inserts
// ^(state & TAPS) at the MSB; the output bit is always state[0].
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset (state resets to 1)
//   i_load, i_seed   : load i_seed into the state (has priority over i_ce)
//   i_ce             : advance one step
//   o_bit            : current output bit, state[0]
// -----------------------------------------------------------------------------
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int              LN   = 8,
    parameter logic [LN-1:0]   TAPS = LN'(default_taps(LN))
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_load,
    input  logic [LN-1:0] i_seed,
    input  logic          i_ce,
    output logic          o_bit
);

    logic [LN-1:0] state_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= LN'(1);
        end else if (i_load) begin
            state_q <= i_seed;
        end else if (i_ce) begin
            state_q <= {^(state_q & TAPS), state_q[LN-1:1]};
        end
    end

    assign o_bit = state_q[0];

endmodule

// File: rtl/prbs_burst_ctrl.sv
// -----------------------------------------------------------------------------
// prbs_burst_ctrl
// Accepts a (seed, length) command, runs the LFSR for exactly that many bits
// and packs them LSB-first into OW-bit words on a valid/ready output.
// Ports:
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready : command handshake (ready only in IDLE)
//   i_cmd_seed, i_cmd_len   : LFSR seed and burst length in bits
//   i_abort                 : drop the current burst, back to IDLE
//   o_word_valid/i_word_ready, o_word, o_word_last : packed output stream
//   o_busy                  : sequencer not in IDLE
//   o_done                  : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module prbs_burst_ctrl
    import prbs_pkg::*;
#(
    parameter int            LN   = 8,
    parameter logic [LN-1:0] TAPS = LN'(default_taps(LN)),
    parameter int            OW   = 8,
    parameter int            LW   = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [LN-1:0] i_cmd_seed,
    input  logic [LW-1:0] i_cmd_len,
    input  logic          i_abort,
    output logic          o_word_valid,
    input  logic          i_word_ready,
    output logic [OW-1:0] o_word,
    output logic          o_word_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int            PW     = $clog2(OW + 1);
    localparam logic [PW-1:0] OW_CNT = PW'(OW);

    state_e        state_q;
    logic [LN-1:0] seed_q;
    logic [LW-1:0] bit_cnt_q;
    logic [OW-1:0] pack_q, pack_d;
    logic [PW-1:0] pack_cnt_q, pack_cnt_d;
    logic [OW-1:0] word_q;
    logic          word_valid_q, word_last_q, done_q, busy_q, cmd_ready_q;

    logic lfsr_bit;
    logic out_free;
    logic xfer_due;
    logic xfer;
    logic gen_en;
    logic last_bit;
    logic abort_act;

    assign abort_act = i_abort && (state_q != IDLE);

    // The output register can take a new word if empty or being emptied now.
    assign out_free = !word_valid_q || i_word_ready;

    // A full pack register in RUN, or any leftover bits in DRAIN, must move out.
    assign xfer_due = ((state_q == RUN)   && (pack_cnt_q == OW_CNT)) ||
                      ((state_q == DRAIN) && (pack_cnt_q != '0));
    assign xfer     = xfer_due && out_free;

    // The LFSR only stalls when the pack register is full and cannot drain.
    assign gen_en   = (state_q == RUN) && !(xfer_due && !out_free) && !i_abort;
    assign last_bit = gen_en && (bit_cnt_q == LW'(1));

    prbs_lfsr_core #(
        .LN   (LN),
        .TAPS (TAPS)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    ((state_q == LOAD) && !i_abort),
        .i_seed    (seed_q),
        .i_ce      (gen_en),
        .o_bit     (lfsr_bit)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pack_d     = pack_q;
        pack_cnt_d = pack_cnt_q;
        if (xfer) begin
            pack_d     = '0;
            pack_cnt_d = '0;
        end
        if (gen_en) begin
            pack_d     = pack_d | (OW'(lfsr_bit) << pack_cnt_d);
            pack_cnt_d = pack_cnt_d + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            seed_q       <= LN'(ZERO_SEED_SUB);
            bit_cnt_q    <= '0;
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            done_q     <= 1'b0;
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;

            if (word_valid_q && i_word_ready) begin
                word_valid_q <= 1'b0;
            end
            if (xfer) begin
                word_q       <= pack_q;
                word_last_q  <= (state_q == DRAIN);
                word_valid_q <= 1'b1;
            end
            if (gen_en) begin
                bit_cnt_q <= bit_cnt_q - LW'(1);
            end

            if (abort_act) begin
                state_q      <= IDLE;
                word_valid_q <= 1'b0;
                pack_q       <= '0;
                pack_cnt_q   <= '0;
                busy_q       <= 1'b0;
                cmd_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_cmd_valid && cmd_ready_q) begin
                            state_q     <= LOAD;
                            bit_cnt_q   <= i_cmd_len;
                            seed_q      <= (i_cmd_seed == '0) ? LN'(ZERO_SEED_SUB) : i_cmd_seed;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
                        end
                    end
                    LOAD: begin
                        pack_q     <= '0;
                        pack_cnt_q <= '0;
                        if (bit_cnt_q == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (last_bit) begin
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (word_valid_q && word_last_q && i_word_ready) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready  = cmd_ready_q;
    assign o_word_valid = word_valid_q;
    assign o_word       = word_q;
    assign o_word_last  = word_last_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
